puf_challenge_ctrl: RTL and testbench
=====================================

# puf_challenge_ctrl

Challenge-issuing side of the ring-oscillator PUF. Drives the 5-bit challenge into the paired oscillator/counter arrays, gates the oscillators for a fixed window, samples both frozen counts, and compares them. It assembles an NBITS-wide response word plus an unstable-bit mask. It sits between the host/test logic and the two RO counter instances and replaces free-running, uncontrolled counting with a deterministic measurement sequence.

## Interface
- NBITS, 8: response bits per run (1..32)
- WIN, 64: oscillator enable window per bit, clk cycles (≥1)
- CLR_CYC, 2: counter-clear cycles per bit (≥1)
- SETTLE, 4: cycles after oscillators stop before sampling (≥1)
- THRESH, 4: minimum |count_a−count_b| for a bit to be stable (0..255)

- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-high reset (high = reset)
- start  input  1  request a run; sampled only in IDLE
- chal_base  input  5  first challenge of the run; latched on accepted start
- count_a  input  8  frozen count of oscillator array A
- count_b  input  8  frozen count of oscillator array B
- challenge  output  5  oscillator select driven to both arrays
- ro_en  output  1  oscillator enable (gates all ROs)
- cnt_clr  output  1  clear for both RO counters
- busy  output  1  high from accepted start through the done cycle
- done  output  1  one-cycle pulse, run complete
- response  output  NBITS  bit i = (count_a > count_b) for challenge i
- unstable  output  NBITS  bit i = |count_a−count_b| < THRESH for challenge i
- resp_valid  output  1  response/unstable hold a completed run

## Operation
- States: IDLE → CLEAR → RUN → SETTLE → SAMPLE → (CLEAR for the next bit | DONE) → IDLE.
- IDLE: start=1 latches chal_base, sets index i=0, clears response/unstable, drops resp_valid, and enters CLEAR.
- CLEAR: cnt_clr=1, ro_en=0 for CLR_CYC cycles.
- RUN: ro_en=1, cnt_clr=0 for WIN cycles.
- SETTLE: ro_en=0 for SETTLE cycles. Counts are treated as static only here.
- SAMPLE (1 cycle): counts are compared as unsigned 8-bit values.
  - response[i] = count_a > count_b. A tie gives 0.
  - diff = |count_a − count_b| in 9-bit arithmetic, no wrap. unstable[i] = diff < THRESH. With THRESH=0, unstable is always 0.
  - i increments. If i was NBITS−1, go to DONE; otherwise go to CLEAR.
- challenge = (base + i) mod 32. It is held constant through all phases of bit i and wraps 31→0.
- DONE (1 cycle): done=1 and resp_valid=1. resp_valid then stays high until the next accepted start or reset.
- start is ignored while busy=1. It is not queued.
- Counter wrap inside the window is not detected. WIN must be chosen so that the counts stay below 256.

## Timing
- Reset values: challenge=0, ro_en=0, cnt_clr=0, busy=0, done=0, response=0, unstable=0, resp_valid=0, state IDLE.
- Reset asserted mid-run: the next edge forces IDLE with all outputs at reset values. A partial response is discarded.
- Start accepted at edge k: busy=1 and the first CLEAR cycle is k+1.
- Per-bit period P = CLR_CYC + WIN + SETTLE + 1 cycles.
- done is high in cycle k+1+NBITS·P. response and unstable are final in the same cycle.
- busy falls in the cycle after done. A start in that cycle is accepted.
- ro_en and cnt_clr are never high in the same cycle.
- All outputs are registered.

## Test plan
- Reset/idle: rst_n=1 for 3 cycles mid-RUN → all outputs 0, state IDLE, no done pulse.
- Single run, defaults: chal_base=3, count_a=120 and count_b=100 for every bit →
  - done at cycle k+1+8·71=k+569;
  - response=8'hFF, unstable=0;
  - challenge sequence 3..10.
- Tie and threshold: THRESH=4, per-bit (a,b) = (50,50), (50,53), (50,54), (60,10) →
  - response bits 0,0,0,1;
  - unstable bits 1,1,0,0.
- Challenge wrap: chal_base=30, NBITS=4 → challenge observed as 30, 31, 0, 1 during each RUN.
- Start while busy: pulse start at cycles k+10 and k+300 → no restart, done exactly once at k+569. Then start in the cycle after done is accepted.
- Phase timing: check ro_en high for exactly WIN=64 cycles per bit, cnt_clr for exactly 2, and never both high together. Counts sampled only in SAMPLE: changing count_a during RUN has no effect.

Source files
------------

// File: rtl/puf_challenge_ctrl_if.sv
// puf_challenge_ctrl_if
//   Bundles the host handshake, the oscillator-array control lines and the
//   frozen counts for the RO PUF challenge controller.
//   master : host/test side plus the two RO counter arrays (drive start,
//            chal_base, count_a, count_b; observe everything else)
//   slave  : the controller itself
//   Signals:
//     start, chal_base[4:0]       run request and first challenge
//     count_a[7:0], count_b[7:0]  frozen counts of arrays A and B
//     challenge[4:0], ro_en,      oscillator select, enable and counter clear
//     cnt_clr
//     busy, done, resp_valid      run status
//     response, unstable          NBITS-wide result words
interface puf_challenge_ctrl_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic [4:0]       chal_base;
    logic [7:0]       count_a;
    logic [7:0]       count_b;
    logic [4:0]       challenge;
    logic             ro_en;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] response;
    logic [NBITS-1:0] unstable;
    logic             resp_valid;

    modport master (
        output start, chal_base, count_a, count_b,
        input  challenge, ro_en, cnt_clr, busy, done, response, unstable, resp_valid
    );

    modport slave (
        input  start, chal_base, count_a, count_b,
        output challenge, ro_en, cnt_clr, busy, done, response, unstable, resp_valid
    );
endinterface

// File: rtl/puf_challenge_ctrl.sv
// puf_challenge_ctrl
//   Challenge-issuing controller for a ring-oscillator PUF. For each of NBITS
//   challenges (base+i mod 32) it clears both RO counters, enables the
//   oscillators for WIN cycles, waits SETTLE cycles for the counts to freeze,
//   then compares count_a against count_b to build one response bit and one
//   unstable-bit flag.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous reset, active HIGH despite the legacy name
//     bus    puf_challenge_ctrl_if slave modport (handshake, RO control,
//            counts, response/unstable words)
//   All outputs are registered; the output registers are loaded with the
//   values belonging to the state being entered.
module puf_challenge_ctrl #(
    parameter int NBITS   = 8,
    parameter int WIN     = 64,
    parameter int CLR_CYC = 2,
    parameter int SETTLE  = 4,
    parameter int THRESH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    puf_challenge_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // One phase counter serves CLEAR, RUN and SETTLE, so it is sized for the
    // longest of the three.
    localparam int PH_MAX = (WIN > CLR_CYC) ? ((WIN > SETTLE) ? WIN : SETTLE)
                                            : ((CLR_CYC > SETTLE) ? CLR_CYC : SETTLE);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int IDX_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [2:0]       state;
    logic [PH_W-1:0]  ph_cnt;
    logic [IDX_W-1:0] idx;
    logic [4:0]       base;

    // Unsigned distance between the two counts; the extra bit keeps the
    // subtraction from wrapping.
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        if (a >= b)
            return {1'b0, a} - {1'b0, b};
        else
            return {1'b0, b} - {1'b0, a};
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state          <= S_IDLE;
            ph_cnt         <= '0;
            idx            <= '0;
            base           <= '0;
            bus.challenge  <= '0;
            bus.ro_en      <= 1'b0;
            bus.cnt_clr    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.response   <= '0;
            bus.unstable   <= '0;
            bus.resp_valid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        base           <= bus.chal_base;
                        bus.challenge  <= bus.chal_base;
                        idx            <= '0;
                        ph_cnt         <= '0;
                        bus.response   <= '0;
                        bus.unstable   <= '0;
                        bus.resp_valid <= 1'b0;
                        bus.busy       <= 1'b1;
                        bus.cnt_clr    <= 1'b1;
                        state          <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (ph_cnt == PH_W'(CLR_CYC - 1)) begin
                        ph_cnt      <= '0;
                        bus.cnt_clr <= 1'b0;
                        bus.ro_en   <= 1'b1;
                        state       <= S_RUN;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (ph_cnt == PH_W'(WIN - 1)) begin
                        ph_cnt    <= '0;
                        bus.ro_en <= 1'b0;
                        state     <= S_SETTLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (ph_cnt == PH_W'(SETTLE - 1)) begin
                        ph_cnt <= '0;
                        state  <= S_SAMPLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    // Ties resolve to 0; with THRESH=0 no bit is ever unstable.
                    bus.response[idx] <= (bus.count_a > bus.count_b);
                    bus.unstable[idx] <= (abs_diff(bus.count_a, bus.count_b) < 9'(THRESH));
                    if (idx == IDX_W'(NBITS - 1)) begin
                        bus.done       <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        idx           <= idx + 1'b1;
                        // 5-bit sum wraps 31 -> 0 on its own.
                        bus.challenge <= base + 5'(idx) + 5'd1;
                        bus.cnt_clr   <= 1'b1;
                        state         <= S_CLEAR;
                    end
                end

                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
module tb_puf_challenge_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    int tab_a [32];
    int tab_b [32];

    puf_challenge_ctrl_if #(.NBITS(8)) ifa ();
    puf_challenge_ctrl_if #(.NBITS(4)) ifb ();

    puf_challenge_ctrl #(.NBITS(8), .WIN(64), .CLR_CYC(2), .SETTLE(4), .THRESH(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    puf_challenge_ctrl #(.NBITS(4), .WIN(8), .CLR_CYC(1), .SETTLE(1), .THRESH(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: ro_en / cnt_clr run lengths, challenge seen at each RUN entry.
    int ro_runs[$];
    int clr_runs[$];
    int chal_q[$];
    int chal_q_b[$];
    int overlap_a;
    int ro_len, clr_len, ro_len_b;

    initial begin
        overlap_a = 0; ro_len = 0; clr_len = 0; ro_len_b = 0;
        forever begin
            @(negedge clk);
            if (ifa.ro_en && ifa.cnt_clr) overlap_a++;
            if (ifa.ro_en) begin
                if (ro_len == 0) chal_q.push_back(int'(ifa.challenge));
                ro_len++;
            end else if (ro_len != 0) begin
                ro_runs.push_back(ro_len);
                ro_len = 0;
            end
            if (ifa.cnt_clr) clr_len++;
            else if (clr_len != 0) begin
                clr_runs.push_back(clr_len);
                clr_len = 0;
            end
            if (ifb.ro_en) begin
                if (ro_len_b == 0) chal_q_b.push_back(int'(ifb.challenge));
                ro_len_b++;
            end else begin
                ro_len_b = 0;
            end
        end
    end

    // RO array model: counts are garbage while counters clear or oscillators
    // run, and become the per-challenge table value once frozen.
    initial begin
        forever begin
            @(negedge clk);
            if (ifa.ro_en || ifa.cnt_clr) begin
                ifa.count_a = 8'($urandom);
                ifa.count_b = 8'($urandom);
            end else begin
                ifa.count_a = 8'(tab_a[ifa.challenge]);
                ifa.count_b = 8'(tab_b[ifa.challenge]);
            end
            if (ifb.ro_en || ifb.cnt_clr) begin
                ifb.count_a = 8'($urandom);
                ifb.count_b = 8'($urandom);
            end else begin
                ifb.count_a = 8'(tab_a[ifb.challenge]);
                ifb.count_b = 8'(tab_b[ifb.challenge]);
            end
        end
    end

    // Reference: bit i compares the frozen counts of challenge (base+i) mod 32.
    function automatic void model(input logic [4:0] base, input int nb, input int thr,
                                  output logic [31:0] r, output logic [31:0] u);
        r = '0;
        u = '0;
        for (int i = 0; i < nb; i++) begin
            int ch, a, b, d;
            ch = (int'(base) + i) % 32;
            a = tab_a[ch];
            b = tab_b[ch];
            d = (a > b) ? a - b : b - a;
            r[i] = (a > b);
            u[i] = (d < thr);
        end
    endfunction

    task automatic randomize_tables();
        for (int c = 0; c < 32; c++) begin
            tab_a[c] = int'($urandom_range(255, 0));
            tab_b[c] = int'($urandom_range(255, 0));
        end
    endtask

    // Leaves the caller at the negedge of the first CLEAR cycle; k is the
    // accepting edge.
    task automatic start_run(input bit on_b, input logic [4:0] base, output int k);
        @(negedge clk);
        if (on_b) begin
            ifb.chal_base = base;
            ifb.start = 1'b1;
        end else begin
            ifa.chal_base = base;
            ifa.start = 1'b1;
        end
        k = cyc + 1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic wait_done(input bit on_b, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            if (on_b ? ifb.done : ifa.done) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ifa.challenge, ifa.ro_en, ifa.cnt_clr, ifa.busy, ifa.done, ifa.response,
             ifa.unstable, ifa.resp_valid} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%h required 0", {ifa.challenge, ifa.ro_en, ifa.cnt_clr,
                     ifa.busy, ifa.done, ifa.response, ifa.unstable, ifa.resp_valid});
        end
        n_checks++;
        if ({ifb.challenge, ifb.ro_en, ifb.cnt_clr, ifb.busy, ifb.done, ifb.response,
             ifb.unstable, ifb.resp_valid} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs=%h required 0", {ifb.challenge, ifb.ro_en, ifb.cnt_clr,
                     ifb.busy, ifb.done, ifb.response, ifb.unstable, ifb.resp_valid});
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_default_run();
        int k, at, q0, c0, h0, ov0;
        for (int c = 0; c < 32; c++) begin
            tab_a[c] = 120;
            tab_b[c] = 100;
        end
        q0 = ro_runs.size(); c0 = clr_runs.size(); h0 = chal_q.size(); ov0 = overlap_a;
        start_run(1'b0, 5'd3, k);
        n_checks++;
        if ({ifa.busy, ifa.cnt_clr, ifa.ro_en} !== 3'b110) begin
            n_fail++;
            $display("FAIL first_clear: busy/cnt_clr/ro_en=%b required 110",
                     {ifa.busy, ifa.cnt_clr, ifa.ro_en});
        end
        wait_done(1'b0, 700, at);
        n_checks++;
        if (at - k != 568) begin
            n_fail++;
            $display("FAIL done_latency: got %0d required 568", at - k);
        end
        n_checks++;
        if (ifa.response !== 8'hFF || ifa.unstable !== 8'h00 || ifa.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL default_result: resp=%h unst=%h vld=%b required FF 00 1",
                     ifa.response, ifa.unstable, ifa.resp_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({ifa.busy, ifa.done, ifa.resp_valid} !== 3'b001) begin
            n_fail++;
            $display("FAIL after_done: busy/done/vld=%b required 001",
                     {ifa.busy, ifa.done, ifa.resp_valid});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (ro_runs.size() - q0 != 8 || clr_runs.size() - c0 != 8 || chal_q.size() - h0 != 8) begin
            n_fail++;
            $display("FAIL phase_count: ro=%0d clr=%0d chal=%0d required 8 each",
                     ro_runs.size() - q0, clr_runs.size() - c0, chal_q.size() - h0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (ro_runs[q0+i] != 64 || clr_runs[c0+i] != 2 || chal_q[h0+i] != 3 + i) begin
                    n_fail++;
                    $display("FAIL phase_bit%0d: ro_len=%0d clr_len=%0d chal=%0d required 64 2 %0d",
                             i, ro_runs[q0+i], clr_runs[c0+i], chal_q[h0+i], 3 + i);
                end
            end
        end
        n_checks++;
        if (overlap_a != ov0) begin
            n_fail++;
            $display("FAIL overlap: ro_en&cnt_clr cycles=%0d required 0", overlap_a - ov0);
        end
    endtask

    task automatic test_reset_midrun();
        int k, n, dones;
        start_run(1'b0, 5'($urandom), k);
        n = 0;
        while (!ifa.ro_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (ifa.ro_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_run: ro_en=%b required 1", ifa.ro_en);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ifa.challenge, ifa.ro_en, ifa.cnt_clr, ifa.busy, ifa.done, ifa.response,
                 ifa.unstable, ifa.resp_valid} !== 26'd0) begin
                n_fail++;
                $display("FAIL midrun_reset_%0d: outputs=%h required 0", c, {ifa.challenge,
                         ifa.ro_en, ifa.cnt_clr, ifa.busy, ifa.done, ifa.response, ifa.unstable,
                         ifa.resp_valid});
            end
        end
        rst_n = 1'b0;
        dones = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (ifa.done) dones++;
        end
        n_checks++;
        if (dones != 0 || ifa.busy !== 1'b0 || ifa.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: dones=%0d busy=%b vld=%b required 0 0 0",
                     dones, ifa.busy, ifa.resp_valid);
        end
    endtask

    task automatic test_tie_thresh();
        int k, at;
        logic [31:0] r, u;
        randomize_tables();
        tab_a[0] = 50; tab_b[0] = 50;
        tab_a[1] = 50; tab_b[1] = 53;
        tab_a[2] = 50; tab_b[2] = 54;
        tab_a[3] = 60; tab_b[3] = 10;
        model(5'd0, 8, 4, r, u);
        start_run(1'b0, 5'd0, k);
        wait_done(1'b0, 700, at);
        n_checks++;
        if (at < 0 || ifa.response[3:0] !== 4'b1000 || ifa.unstable[3:0] !== 4'b0011) begin
            n_fail++;
            $display("FAIL tie_thresh: at=%0d resp[3:0]=%b unst[3:0]=%b required 1000 0011",
                     at, ifa.response[3:0], ifa.unstable[3:0]);
        end
        n_checks++;
        if (ifa.response !== r[7:0] || ifa.unstable !== u[7:0]) begin
            n_fail++;
            $display("FAIL tie_full: resp=%h unst=%h required %h %h",
                     ifa.response, ifa.unstable, r[7:0], u[7:0]);
        end
    endtask

    task automatic test_wrap();
        int k, at, h0;
        logic [31:0] r, u;
        int exp_ch [4];
        exp_ch = '{30, 31, 0, 1};
        randomize_tables();
        tab_a[30] = 5;   tab_b[30] = 5;
        tab_a[31] = 200; tab_b[31] = 3;
        tab_a[0]  = 0;   tab_b[0]  = 255;
        tab_a[1]  = 7;   tab_b[1]  = 6;
        model(5'd30, 4, 0, r, u);
        h0 = chal_q_b.size();
        start_run(1'b1, 5'd30, k);
        wait_done(1'b1, 100, at);
        n_checks++;
        if (at - k != 44 || ifb.response !== r[3:0] || ifb.unstable !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_run: lat=%0d resp=%b unst=%b required 44 %b 0000",
                     at - k, ifb.response, ifb.unstable, r[3:0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (chal_q_b.size() - h0 != 4) begin
            n_fail++;
            $display("FAIL wrap_count: runs=%0d required 4", chal_q_b.size() - h0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (chal_q_b[h0+i] != exp_ch[i]) begin
                    n_fail++;
                    $display("FAIL wrap_chal%0d: got %0d required %0d", i, chal_q_b[h0+i], exp_ch[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k, k2, at, q0;
        logic [4:0] base, base2;
        logic [31:0] r, u;
        randomize_tables();
        base = 5'($urandom);
        base2 = 5'($urandom);
        q0 = ro_runs.size();
        start_run(1'b0, base, k);
        at = -1;
        while (at < 0 && cyc < k + 700) begin
            if (ifa.done) at = cyc;
            else begin
                ifa.start = (cyc == k + 9) || (cyc == k + 299);
                ifa.chal_base = 5'($urandom);
                @(negedge clk);
            end
        end
        ifa.start = 1'b0;
        model(base, 8, 4, r, u);
        n_checks++;
        if (at - k != 568) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d required 568", at - k);
        end
        n_checks++;
        if (ifa.response !== r[7:0] || ifa.unstable !== u[7:0]) begin
            n_fail++;
            $display("FAIL busy_start_result: resp=%h unst=%h required %h %h",
                     ifa.response, ifa.unstable, r[7:0], u[7:0]);
        end
        // Start raised in the done cycle is ignored there, then accepted in
        // the following idle cycle.
        ifa.chal_base = base2;
        ifa.start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: busy=%b done=%b required 0 0", ifa.busy, ifa.done);
        end
        @(negedge clk);
        ifa.start = 1'b0;
        k2 = cyc;
        n_checks++;
        if ({ifa.busy, ifa.cnt_clr, ifa.resp_valid} !== 3'b110 || ifa.response !== 8'h00 ||
            ifa.challenge !== base2) begin
            n_fail++;
            $display("FAIL restart: busy/clr/vld=%b resp=%h chal=%0d required 110 00 %0d",
                     {ifa.busy, ifa.cnt_clr, ifa.resp_valid}, ifa.response, ifa.challenge, base2);
        end
        n_checks++;
        if (ro_runs.size() - q0 != 8) begin
            n_fail++;
            $display("FAIL no_restart: ro windows=%0d required 8", ro_runs.size() - q0);
        end
        wait_done(1'b0, 700, at);
        model(base2, 8, 4, r, u);
        n_checks++;
        if (at - k2 != 568 || ifa.response !== r[7:0] || ifa.unstable !== u[7:0]) begin
            n_fail++;
            $display("FAIL second_run: lat=%0d resp=%h unst=%h required 568 %h %h",
                     at - k2, ifa.response, ifa.unstable, r[7:0], u[7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random_runs();
        int k, at;
        logic [4:0] base;
        logic [31:0] r, u;
        for (int t = 0; t < 3; t++) begin
            randomize_tables();
            // Force a few near-threshold pairs so unstable bits are exercised.
            for (int c = 0; c < 32; c += 3) tab_b[c] = (tab_a[c] + int'($urandom_range(6, 0))) % 256;
            base = 5'($urandom);
            model(base, 8, 4, r, u);
            start_run(1'b0, base, k);
            wait_done(1'b0, 700, at);
            n_checks++;
            if (at - k != 568 || ifa.response !== r[7:0] || ifa.unstable !== u[7:0]) begin
                n_fail++;
                $display("FAIL random_run%0d: base=%0d lat=%0d resp=%h unst=%h required 568 %h %h",
                         t, base, at - k, ifa.response, ifa.unstable, r[7:0], u[7:0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b1;
        ifa.start = 1'b0; ifa.chal_base = '0;
        ifb.start = 1'b0; ifb.chal_base = '0;
        for (int c = 0; c < 32; c++) begin
            tab_a[c] = 0;
            tab_b[c] = 0;
        end
        test_reset();
        test_default_run();
        test_reset_midrun();
        test_tie_thresh();
        test_wrap();
        test_back_to_back();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
